plb_adc_capture: RTL and testbench

- Receive-direction companion to the PLB DAC core. It generates the ADC conversion clock, discards the ADC pipeline latency, and converts samples to two's complement.
- Samples are buffered in a small synchronous FIFO. The PLB slave logic drains the FIFO through a one-request/one-acknowledge read handshake.
- Sits between the ADC pins and the PLB IPIF register/memory decode, in the SPLB_Clk domain only.

---
 rtl/plb_adc_capture_pkg.sv | 31 +++
 rtl/plb_adc_capture_fifo.sv | 78 +++++++
 rtl/plb_adc_capture.sv | 191 +++++++++++++++++++
 tb/tb_plb_adc_capture.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plb_adc_capture_pkg.sv
// Shared definitions for the PLB ADC capture block.
//   captureStateT : capture state machine encoding (IDLE, PRIME, RUN)
//   clog2         : ceiling log2, usable in parameter/port width expressions
//   DEF_*         : default parameter values for the capture core and FIFO
package plb_adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } captureStateT;

  localparam int DEF_ADC_WIDTH   = 10;
  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_ADC_LATENCY = 5;
  localparam int DEF_FIFO_DEPTH  = 16;

  // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/plb_adc_capture_fifo.sv
// Synchronous FIFO with registered read data.
//   clk      : clock
//   rstN     : asynchronous active-low reset (pointers and count)
//   clear    : flush; wins over push and pop in the same cycle
//   push     : write pushData (ignored when full unless a pop happens too)
//   pop      : read oldest entry into popData (ignored when empty)
//   popData  : registered read data, updated only on a successful pop
//   full     : occupancy equals DEPTH
//   empty    : occupancy is zero
//   count    : current occupancy, 0..DEPTH
module plb_adc_capture_fifo
  import plb_adc_capture_pkg::*;
#(
  parameter int WIDTH = DEF_ADC_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      countQ;
  logic             pushOk;
  logic             popOk;

  assign full  = (countQ == DEPTH_CNT);
  assign empty = (countQ == '0);
  assign count = countQ;

  // A pop never sees data pushed in the same cycle (no fall-through).
  // When full, a simultaneous pop frees the slot the push writes into;
  // since wrPtr == rdPtr then, the read below takes the old entry first.
  assign popOk  = pop & ~empty & ~clear;
  assign pushOk = push & ~clear & (~full | popOk);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else if (clear) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (popOk) popData <= mem[rdPtr];
  end

endmodule

// File: rtl/plb_adc_capture.sv
// ADC capture core: conversion clock generation, pipeline-latency priming,
// offset-binary to two's-complement conversion, FIFO buffering and a
// request/acknowledge read port for the PLB slave logic.
//   SPLB_Clk   : single clock
//   SPLB_Rst_n : asynchronous active-low reset
//   Enable     : level, capture running
//   Clear      : pulse, flush FIFO and clear Overflow
//   Format_Sel : 0 = ADC offset binary, 1 = ADC two's complement
//   A_Data     : ADC parallel output
//   A_Clkout   : ADC conversion clock
//   A_PWRDN    : ADC power-down (high in IDLE)
//   Rd_Req     : one-cycle read request
//   Rd_Ack     : one-cycle acknowledge, the cycle after Rd_Req
//   Rd_Valid   : Rd_Data holds a real sample (only with Rd_Ack)
//   Rd_Data    : last read sample, zero after an empty read
//   Fill_Level : FIFO occupancy
//   Overflow   : sticky, a sample was dropped on a full FIFO
//   Capturing  : high in RUN
module plb_adc_capture
  import plb_adc_capture_pkg::*;
#(
  parameter int ADC_WIDTH   = DEF_ADC_WIDTH,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int ADC_LATENCY = DEF_ADC_LATENCY,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                       SPLB_Clk,
  input  logic                       SPLB_Rst_n,
  input  logic                       Enable,
  input  logic                       Clear,
  input  logic                       Format_Sel,
  input  logic [ADC_WIDTH-1:0]       A_Data,
  output logic                       A_Clkout,
  output logic                       A_PWRDN,
  input  logic                       Rd_Req,
  output logic                       Rd_Ack,
  output logic                       Rd_Valid,
  output logic [ADC_WIDTH-1:0]       Rd_Data,
  output logic [clog2(FIFO_DEPTH):0] Fill_Level,
  output logic                       Overflow,
  output logic                       Capturing
);

  localparam int DIV_W   = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
  localparam int PRIME_W = (clog2(ADC_LATENCY + 1) < 1) ? 1 : clog2(ADC_LATENCY + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF   = DIV_W'(CLK_DIV / 2);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(ADC_LATENCY - 1);

  captureStateT       stateQ;
  captureStateT       stateNext;
  logic [DIV_W-1:0]   divCnt;
  logic [DIV_W-1:0]   divNext;
  logic [PRIME_W-1:0] primeCnt;
  logic [PRIME_W-1:0] primeNext;
  logic               strobe;
  logic               aClkoutQ;

  logic [ADC_WIDTH-1:0] convData;
  logic                 pushReq;
  logic                 fifoPush;
  logic                 fifoPop;
  logic [ADC_WIDTH-1:0] fifoPopData;
  logic                 fifoFull;
  logic                 fifoEmpty;

  logic rdAckQ;
  logic lastValidQ;
  logic overflowQ;

  // ---------------------------------------------------------------------
  // State machine and conversion-clock divider
  // ---------------------------------------------------------------------
  always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
    if (!SPLB_Rst_n) begin
      stateQ   <= IDLE;
      divCnt   <= '0;
      primeCnt <= '0;
      aClkoutQ <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      divCnt   <= divNext;
      primeCnt <= primeNext;
      // High for the first half of each divider period; low while the
      // strobe samples A_Data so the ADC output has settled.
      aClkoutQ <= (stateNext != IDLE) && (divNext < DIV_HALF);
    end
  end

  always_comb begin
    stateNext = stateQ;
    divNext   = divCnt;
    primeNext = primeCnt;
    strobe    = 1'b0;
    case (stateQ)
      IDLE: begin
        divNext   = '0;
        primeNext = '0;
        if (Enable) stateNext = (ADC_LATENCY == 0) ? RUN : PRIME;
      end
      PRIME, RUN: begin
        if (!Enable) begin
          // Dropping Enable abandons any conversion in progress.
          stateNext = IDLE;
          divNext   = '0;
          primeNext = '0;
        end else if (divCnt == DIV_LAST) begin
          divNext = '0;
          strobe  = 1'b1;
          if (stateQ == PRIME) begin
            primeNext = primeCnt + 1'b1;
            if (primeCnt == PRIME_LAST) stateNext = RUN;
          end
        end else begin
          divNext = divCnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        divNext   = '0;
        primeNext = '0;
      end
    endcase
  end

  assign A_Clkout  = aClkoutQ;
  assign A_PWRDN   = (stateQ == IDLE);
  assign Capturing = (stateQ == RUN);

  // ---------------------------------------------------------------------
  // Offset binary -> two's complement: flipping the MSB subtracts
  // 2^(ADC_WIDTH-1) modulo 2^ADC_WIDTH.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < ADC_WIDTH; gi++) begin : gConv
    if (gi == ADC_WIDTH - 1) begin : gMsb
      assign convData[gi] = A_Data[gi] ^ ~Format_Sel;
    end else begin : gLow
      assign convData[gi] = A_Data[gi];
    end
  end

  // ---------------------------------------------------------------------
  // Sample buffer
  // ---------------------------------------------------------------------
  assign pushReq  = strobe & (stateQ == RUN);
  assign fifoPush = pushReq & ~Clear;
  assign fifoPop  = Rd_Req & ~Clear;

  plb_adc_capture_fifo #(
    .WIDTH (ADC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (SPLB_Clk),
    .rstN     (SPLB_Rst_n),
    .clear    (Clear),
    .push     (fifoPush),
    .pushData (convData),
    .pop      (fifoPop),
    .popData  (fifoPopData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (Fill_Level)
  );

  // ---------------------------------------------------------------------
  // Read handshake and overflow flag
  // ---------------------------------------------------------------------
  always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
    if (!SPLB_Rst_n) begin
      rdAckQ     <= 1'b0;
      lastValidQ <= 1'b0;
      overflowQ  <= 1'b0;
    end else begin
      rdAckQ <= Rd_Req;
      // Remember whether the latest request popped data; the FIFO read
      // register holds that sample until the next successful pop.
      if (Rd_Req) lastValidQ <= fifoPop & ~fifoEmpty;
      if (Clear) begin
        overflowQ <= 1'b0;
      end else if (fifoPush && fifoFull && !fifoPop) begin
        overflowQ <= 1'b1;
      end
    end
  end

  assign Rd_Ack   = rdAckQ;
  assign Rd_Valid = rdAckQ & lastValidQ;
  assign Rd_Data  = lastValidQ ? fifoPopData : '0;
  assign Overflow = overflowQ;

endmodule

// File: tb/tb_plb_adc_capture.sv
module tb_plb_adc_capture;

  localparam int W     = 10;
  localparam int DIV   = 4;
  localparam int LAT   = 5;
  localparam int DEPTH = 16;

  logic         SPLB_Clk   = 1'b0;
  logic         SPLB_Rst_n = 1'b0;
  logic         Enable     = 1'b0;
  logic         Clear      = 1'b0;
  logic         Format_Sel = 1'b0;
  logic [W-1:0] A_Data     = '0;
  logic         Rd_Req     = 1'b0;
  logic         A_Clkout;
  logic         A_PWRDN;
  logic         Rd_Ack;
  logic         Rd_Valid;
  logic [W-1:0] Rd_Data;
  logic [4:0]   Fill_Level;
  logic         Overflow;
  logic         Capturing;

  always #5 SPLB_Clk = ~SPLB_Clk;

  plb_adc_capture #(
    .ADC_WIDTH   (W),
    .CLK_DIV     (DIV),
    .ADC_LATENCY (LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .SPLB_Clk   (SPLB_Clk),
    .SPLB_Rst_n (SPLB_Rst_n),
    .Enable     (Enable),
    .Clear      (Clear),
    .Format_Sel (Format_Sel),
    .A_Data     (A_Data),
    .A_Clkout   (A_Clkout),
    .A_PWRDN    (A_PWRDN),
    .Rd_Req     (Rd_Req),
    .Rd_Ack     (Rd_Ack),
    .Rd_Valid   (Rd_Valid),
    .Rd_Data    (Rd_Data),
    .Fill_Level (Fill_Level),
    .Overflow   (Overflow),
    .Capturing  (Capturing)
  );

  int compared   = 0;
  int mismatched = 0;
  int readCount  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mT counts cycles since capture was enabled; conversion k (1-based)
  // ends on the cycle where mT = k*DIV-1, and only k > LAT are kept.
  bit           mActive;
  int           mT;
  logic [W-1:0] mQ[$];
  bit           mOvf;
  bit           mAck;
  bit           mLastValid;
  logic [W-1:0] mLastData;

  function automatic logic [W-1:0] toTwos(input logic [W-1:0] d, input logic fmt);
    int v;
    if (fmt) return d;
    v = int'(d) - (1 << (W - 1));
    return W'(v);
  endfunction

  task automatic modelReset();
    mActive = 0; mT = 0; mQ.delete(); mOvf = 0;
    mAck = 0; mLastValid = 0; mLastData = '0;
  endtask

  task automatic modelEdge();
    bit strobe;
    bit popped;
    logic [W-1:0] val;
    int idx;
    strobe = 0; popped = 0; val = '0; idx = 0;
    if (!mActive) begin
      if (Enable) begin mActive = 1; mT = 0; end
    end else if (!Enable) begin
      mActive = 0; mT = 0;
    end else begin
      strobe = ((mT % DIV) == DIV - 1);
      idx    = mT / DIV + 1;
      mT++;
    end
    mAck = Rd_Req;
    if (Clear) begin mQ.delete(); mOvf = 0; end
    if (Rd_Req) begin
      if (!Clear && mQ.size() > 0) begin val = mQ.pop_front(); popped = 1; end
      mLastValid = popped;
      mLastData  = val;
    end
    if (strobe && idx > LAT && !Clear) begin
      if (mQ.size() < DEPTH) mQ.push_back(toTwos(A_Data, Format_Sel));
      else mOvf = 1;
    end
  endtask

  task automatic checkOutputs();
    checkVal("rd_ack",     Rd_Ack,     mAck);
    checkVal("rd_valid",   Rd_Valid,   mAck && mLastValid);
    checkVal("rd_data",    Rd_Data,    mLastValid ? mLastData : '0);
    checkVal("fill_level", Fill_Level, mQ.size());
    checkVal("overflow",   Overflow,   mOvf);
    checkVal("capturing",  Capturing,  mActive && (mT / DIV >= LAT));
    checkVal("a_pwrdn",    A_PWRDN,    !mActive);
    checkVal("a_clkout",   A_Clkout,   mActive && ((mT % DIV) < DIV / 2));
    if (Rd_Ack) begin
      readCount++;
      $display("read %0d: valid=%0d data=%03h fill=%0d ovf=%0d",
               readCount, Rd_Valid, Rd_Data, Fill_Level, Overflow);
    end
  endtask

  task automatic step(input logic en, input logic req, input logic clr,
                      input logic fmt, input logic [W-1:0] data);
    Enable = en; Rd_Req = req; Clear = clr; Format_Sel = fmt; A_Data = data;
    modelEdge();
    @(posedge SPLB_Clk);
    #1;
    checkOutputs();
  endtask

  task automatic rstep(input logic en, input int reqPct, input int clrPct);
    step(en, int'($urandom_range(0, 99)) < reqPct, int'($urandom_range(0, 99)) < clrPct,
         1'($urandom_range(0, 1)), W'($urandom));
  endtask

  task automatic readOne(output logic valid, output logic [W-1:0] data);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    valid = Rd_Valid;
    data  = Rd_Data;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_pwrdn"},  A_PWRDN,    1);
    checkVal({tag, "_clkout"}, A_Clkout,   0);
    checkVal({tag, "_ack"},    Rd_Ack,     0);
    checkVal({tag, "_valid"},  Rd_Valid,   0);
    checkVal({tag, "_data"},   Rd_Data,    0);
    checkVal({tag, "_fill"},   Fill_Level, 0);
    checkVal({tag, "_ovf"},    Overflow,   0);
    checkVal({tag, "_cap"},    Capturing,  0);
  endtask

  initial begin
    logic         v;
    logic [W-1:0] d;
    int           guard;

    modelReset();

    // Reset with Enable held, then priming and first push timing.
    SPLB_Rst_n = 1'b0;
    Enable     = 1'b1;
    repeat (3) @(posedge SPLB_Clk);
    #1;
    checkResetOutputs("reset");
    SPLB_Rst_n = 1'b1;
    repeat (20) rstep(1'b1, 0, 0);
    checkVal("prime_cap0", Capturing, 0);
    rstep(1'b1, 0, 0);
    checkVal("prime_cap1", Capturing, 1);
    repeat (3) rstep(1'b1, 0, 0);
    checkVal("first_push0", Fill_Level, 0);
    rstep(1'b1, 0, 0);
    checkVal("first_push1", Fill_Level, 1);

    // Format conversion: each 4-cycle window holds exactly one strobe.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    repeat (DIV) step(1'b1, 1'b0, 1'b0, 1'b0, 10'h200);
    repeat (DIV) step(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
    repeat (DIV) step(1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    readOne(v, d); checkVal("fmt0_200_v", v, 1); checkVal("fmt0_200", d, 10'h000);
    readOne(v, d); checkVal("fmt0_000_v", v, 1); checkVal("fmt0_000", d, 10'h200);
    readOne(v, d); checkVal("fmt1_3ff_v", v, 1); checkVal("fmt1_3ff", d, 10'h3FF);
    readOne(v, d); checkVal("empty_v", v, 0); checkVal("empty_d", d, 0);
    checkVal("empty_ack", Rd_Ack, 1);

    // Overfill: 22 strobes, 5 primed, 17 pushes into 16 slots.
    repeat (90) rstep(1'b1, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checkVal("full_fill", Fill_Level, DEPTH);
    checkVal("full_ovf", Overflow, 1);
    repeat (DEPTH) begin
      readOne(v, d);
      checkVal("drain_v", v, 1);
    end
    readOne(v, d);
    checkVal("drain17_ack", Rd_Ack, 1);
    checkVal("drain17_v", v, 0);

    // Full FIFO, strobe and read in the same cycle.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    guard = 0;
    while (mQ.size() < DEPTH && guard < 200) begin rstep(1'b1, 0, 0); guard++; end
    checkVal("fill_wait", Fill_Level, DEPTH);
    guard = 0;
    while ((mT % DIV) != DIV - 1 && guard < 10) begin rstep(1'b1, 0, 0); guard++; end
    checkVal("strobe_wait_ovf", Overflow, 0);
    step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), W'($urandom));
    checkVal("pushpop_ovf", Overflow, 0);
    checkVal("pushpop_fill", Fill_Level, DEPTH);
    checkVal("pushpop_v", Rd_Valid, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (DEPTH) readOne(v, d);

    // Aborted prime after 3 conversions, then a full prime again.
    repeat (13) rstep(1'b1, 0, 0);
    repeat (10) begin
      rstep(1'b0, 0, 0);
      checkVal("abort_pwrdn", A_PWRDN, 1);
    end
    repeat (20) rstep(1'b1, 0, 0);
    checkVal("reprime_cap0", Capturing, 0);
    rstep(1'b1, 0, 0);
    checkVal("reprime_cap1", Capturing, 1);
    repeat (3) rstep(1'b1, 0, 0);
    checkVal("reprime_fill", Fill_Level, 0);

    // Clear with Fill_Level=7 and Overflow set, then mid-RUN reset.
    repeat (90) rstep(1'b1, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (9) readOne(v, d);
    checkVal("pre_clear_fill", Fill_Level, 7);
    checkVal("pre_clear_ovf", Overflow, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    checkVal("clear_fill", Fill_Level, 0);
    checkVal("clear_ovf", Overflow, 0);
    repeat (100) rstep(1'b1, 30, 0);
    checkVal("run_cap", Capturing, 1);
    #3;
    SPLB_Rst_n = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    modelReset();
    @(posedge SPLB_Clk);
    #1;
    SPLB_Rst_n = 1'b1;

    // Random traffic: occasional Enable toggles and clears.
    begin
      logic en;
      en = 1'b1;
      repeat (600) begin
        if ($urandom_range(0, 99) < 2) en = ~en;
        rstep(en, 40, 2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
